// File: rtl/codeword_crc_framer.sv
`default_nettype none
// ============================================================================
// Module   : codeword_crc_framer
// Function : Frames a headerless 32-bit codeword stream. Each codeword of
//            CODEWORD_SIZE_IN_32 payload words is emitted as a header word,
//            the unchanged payload, and a CRC-32/MPEG-2 trailer carrying tlast.
// Revision : 1.0  initial release
// ============================================================================
module codeword_crc_framer #(
  parameter int          CODEWORD_SIZE_IN_32 = 65,
  parameter int          NUM_CODEWORDS       = 4,
  parameter logic [15:0] SYNC_WORD           = 16'hA5C3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [7:0]  blk_seq
);

  localparam logic [7:0]  C_LAST_WORD = 8'(CODEWORD_SIZE_IN_32 - 1);
  localparam logic [7:0]  C_LAST_CW   = 8'(NUM_CODEWORDS - 1);
  localparam logic [31:0] C_CRC_POLY  = 32'h04C1_1DB7;
  localparam logic [31:0] C_CRC_INIT  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_HDR = 2'd0,
    ST_PAY = 2'd1,
    ST_CRC = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_word_cnt, w_word_cnt_nxt;
  logic [7:0]  r_cw_idx, w_cw_idx_nxt;
  logic [7:0]  r_blk_seq, w_blk_seq_nxt;
  logic [31:0] r_crc, w_crc_nxt;
  logic [31:0] r_tdata;
  logic        r_tvalid;
  logic        r_tlast;
  logic        w_slot_free;
  logic        w_load;
  logic        w_load_last;
  logic [31:0] w_load_data;
  logic [31:0] w_crc_step;

  // One full 32-bit CRC step, bit 31 first, non-reflected, no final XOR.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ C_CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  assign w_slot_free   = !r_tvalid || m_axis_tready;
  assign w_crc_step    = crc32_word(r_crc, s_axis_tdata);
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign blk_seq       = r_blk_seq;

  // Next-state, counter/CRC updates and output-slot load selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_word_cnt_nxt = r_word_cnt;
    w_cw_idx_nxt   = r_cw_idx;
    w_blk_seq_nxt  = r_blk_seq;
    w_crc_nxt      = r_crc;
    w_load         = 1'b0;
    w_load_last    = 1'b0;
    w_load_data    = r_tdata;
    s_axis_tready  = 1'b0;
    case (r_state)
      ST_HDR: begin
        // Header only goes out once a payload word is actually waiting.
        if (s_axis_tvalid && w_slot_free) begin
          w_load      = 1'b1;
          w_load_data = {SYNC_WORD, r_cw_idx, r_blk_seq};
          w_state_nxt = ST_PAY;
        end
      end
      ST_PAY: begin
        s_axis_tready = w_slot_free;
        if (s_axis_tvalid && w_slot_free) begin
          w_load      = 1'b1;
          w_load_data = s_axis_tdata;
          w_crc_nxt   = w_crc_step;
          if (r_word_cnt == C_LAST_WORD) begin
            w_word_cnt_nxt = 8'd0;
            w_state_nxt    = ST_CRC;
          end else begin
            w_word_cnt_nxt = r_word_cnt + 8'd1;
          end
        end
      end
      ST_CRC: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_data = r_crc;
          w_load_last = 1'b1;
          w_crc_nxt   = C_CRC_INIT;
          w_state_nxt = ST_HDR;
          if (r_cw_idx == C_LAST_CW) begin
            w_cw_idx_nxt  = 8'd0;
            w_blk_seq_nxt = r_blk_seq + 8'd1;
          end else begin
            w_cw_idx_nxt  = r_cw_idx + 8'd1;
          end
        end
      end
      default: w_state_nxt = ST_HDR;
    endcase
  end

  // FSM state, counters and running CRC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_HDR;
      r_word_cnt <= 8'd0;
      r_cw_idx   <= 8'd0;
      r_blk_seq  <= 8'd0;
      r_crc      <= C_CRC_INIT;
    end else begin
      r_state    <= w_state_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_cw_idx   <= w_cw_idx_nxt;
      r_blk_seq  <= w_blk_seq_nxt;
      r_crc      <= w_crc_nxt;
    end
  end

  // Output slot: load when free, otherwise drain on tready, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tdata  <= 32'd0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (w_load) begin
      r_tdata  <= w_load_data;
      r_tvalid <= 1'b1;
      r_tlast  <= w_load_last;
    end else if (m_axis_tready) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_codeword_crc_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_codeword_crc_framer
// Function : Self-checking bench for codeword_crc_framer; randomized stimulus
//            against a byte-table CRC-32/MPEG-2 framing model.
// Revision : 1.0  initial release
// ============================================================================
module tb_codeword_crc_framer;

  localparam int BUDGET = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic [7:0]  blk_seq;

  logic [31:0] sm_s_tdata = '0;
  logic        sm_s_tvalid = 1'b0;
  logic        sm_s_tready;
  logic [31:0] sm_m_tdata;
  logic        sm_m_tvalid;
  logic        sm_m_tlast;
  logic        sm_m_tready = 1'b0;
  logic [7:0]  sm_blk_seq;

  logic [31:0] in_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  logic [32:0] ref_q[$];
  logic [31:0] crc_tab[256];
  int          m_cw, m_blk;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  codeword_crc_framer u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready), .blk_seq(blk_seq)
  );

  codeword_crc_framer #(.CODEWORD_SIZE_IN_32(2), .NUM_CODEWORDS(1), .SYNC_WORD(16'hA5C3)) u_small (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(sm_s_tdata), .s_axis_tvalid(sm_s_tvalid), .s_axis_tready(sm_s_tready),
    .m_axis_tdata(sm_m_tdata), .m_axis_tvalid(sm_m_tvalid), .m_axis_tlast(sm_m_tlast),
    .m_axis_tready(sm_m_tready), .blk_seq(sm_blk_seq)
  );

  // Byte-wise CRC-32/MPEG-2 table (poly 04C11DB7, MSB first).
  task automatic build_table();
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i) << 24;
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      crc_tab[i] = c;
    end
  endtask

  // Expected framed stream for in_q, continuing from model header state.
  task automatic model_stream(input int cwsz, input int ncw);
    logic [31:0] crc, w;
    logic [7:0]  byt;
    int          pos;
    pos = 0;
    crc = 32'hFFFF_FFFF;
    exp_q.delete();
    for (int i = 0; i < in_q.size(); i++) begin
      if (pos == 0) exp_q.push_back({1'b0, 16'hA5C3, 8'(m_cw), 8'(m_blk)});
      w = in_q[i];
      exp_q.push_back({1'b0, w});
      for (int b = 3; b >= 0; b--) begin
        byt = w[8*b +: 8];
        crc = (crc << 8) ^ crc_tab[crc[31:24] ^ byt];
      end
      pos++;
      if (pos == cwsz) begin
        exp_q.push_back({1'b1, crc});
        crc = 32'hFFFF_FFFF;
        pos = 0;
        m_cw++;
        if (m_cw == ncw) begin
          m_cw = 0;
          m_blk = (m_blk + 1) % 256;
        end
      end
    end
  endtask

  function automatic int stream_diffs();
    int n;
    n = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  task automatic reset_dut();
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cw = 0;
    m_blk = 0;
  endtask

  // Feeds in_q to the main DUT and collects n_exp output beats into got_q.
  task automatic drive(input int n_exp, input int rpct, input int vpct, input int low_win,
                       output int lows, output int hold_bad);
    int          idx, cyc;
    bit          hold;
    logic [31:0] hd;
    logic        hl;
    idx = 0; cyc = 0; hold = 0; hd = '0; hl = 0;
    lows = 0; hold_bad = 0;
    got_q.delete();
    while (got_q.size() < n_exp && cyc < BUDGET) begin
      @(negedge clk);
      if (hold && !(m_tvalid === 1'b1 && m_tdata === hd && m_tlast === hl)) hold_bad++;
      m_tready = ($urandom_range(99) < rpct);
      if (idx < in_q.size()) begin
        s_tvalid = ($urandom_range(99) < vpct);
        s_tdata  = in_q[idx];
      end else begin
        s_tvalid = 1'b0;
      end
      #1;
      if (cyc < low_win && s_tready !== 1'b1) lows++;
      if (s_tvalid && s_tready === 1'b1) idx++;
      if (m_tvalid === 1'b1 && m_tready) got_q.push_back({m_tlast, m_tdata});
      hold = (m_tvalid === 1'b1) && !m_tready;
      hd = m_tdata;
      hl = m_tlast;
      cyc++;
    end
    total++;
    if (got_q.size() < n_exp) begin
      bad++;
      $display("FAIL drive_timeout: got %0d beats, want %0d", got_q.size(), n_exp);
    end
  endtask

  task automatic test_reset();
    int vbad;
    reset_dut();
    vbad = 0;
    m_tready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (m_tvalid !== 1'b0) vbad++;
    end
    total++; if (vbad != 0) begin bad++; $display("FAIL reset_idle_valid: %0d cycles valid, want 0", vbad); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_s_tready: got %b want 0", s_tready); end
    total++; if (blk_seq !== 8'd0) begin bad++; $display("FAIL reset_blk_seq: got %h want 00", blk_seq); end
    total++; if (m_tdata !== 32'd0) begin bad++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
  endtask

  task automatic test_single_codeword();
    int lows, hb, d, nlast;
    logic [32:0] b;
    reset_dut();
    in_q.delete();
    for (int i = 0; i < 65; i++) in_q.push_back(32'(i));
    model_stream(65, 4);
    drive(67, 100, 100, 67, lows, hb);
    d = stream_diffs();
    total++; if (d != 0) begin bad++; $display("FAIL single_stream: %0d diffs, got %0d beats want %0d", d, got_q.size(), exp_q.size()); end
    b = (got_q.size() > 0) ? got_q[0] : '1;
    total++; if (b !== {1'b0, 32'hA5C3_0000}) begin bad++; $display("FAIL single_header: got %h want 0a5c30000", b); end
    nlast = 0;
    foreach (got_q[i]) if (got_q[i][32]) nlast++;
    b = (got_q.size() == 67) ? got_q[66] : '0;
    total++; if (nlast != 1 || b[32] !== 1'b1) begin bad++; $display("FAIL single_tlast: got %0d lasts (beat67 last=%b) want 1", nlast, b[32]); end
    total++; if (lows != 2) begin bad++; $display("FAIL single_stall: got %0d low cycles want 2", lows); end
  endtask

  task automatic test_full_block();
    int lows, hb, d, hbad, cbad;
    logic [32:0] b;
    reset_dut();
    in_q.delete();
    repeat (260) in_q.push_back(32'hFFFF_FFFF);
    model_stream(65, 4);
    drive(268, 100, 100, 0, lows, hb);
    d = stream_diffs();
    total++; if (d != 0) begin bad++; $display("FAIL block_stream: %0d diffs", d); end
    hbad = 0; cbad = 0;
    for (int k = 0; k < 4 && got_q.size() == 268; k++) begin
      if (got_q[k*67] !== {1'b0, 16'hA5C3, 8'(k), 8'h00}) hbad++;
      if (got_q[k*67+66] !== exp_q[66]) cbad++;
    end
    total++; if (hbad != 0 || got_q.size() != 268) begin bad++; $display("FAIL block_headers: %0d bad headers", hbad); end
    total++; if (cbad != 0 || got_q.size() != 268) begin bad++; $display("FAIL block_crcs: %0d crcs differ from %h", cbad, exp_q[66]); end
    @(negedge clk);
    total++; if (blk_seq !== 8'd1) begin bad++; $display("FAIL block_blk_seq: got %h want 01", blk_seq); end
    in_q.delete();
    in_q.push_back(32'h1234_5678);
    drive(1, 100, 100, 0, lows, hb);
    b = (got_q.size() > 0) ? got_q[0] : '1;
    total++; if (b !== {1'b0, 32'hA5C3_0001}) begin bad++; $display("FAIL block_next_header: got %h want 0a5c30001", b); end
  endtask

  task automatic test_backpressure();
    int lows, hb, d, rd;
    reset_dut();
    in_q.delete();
    repeat (8 * 260) in_q.push_back($urandom);
    model_stream(65, 4);
    drive(8 * 268, 100, 100, 0, lows, hb);
    ref_q = got_q;
    reset_dut();
    drive(8 * 268, 50, 70, 0, lows, hb);
    rd = (got_q.size() != ref_q.size()) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) if (got_q[i] !== ref_q[i]) rd++;
    total++; if (rd != 0) begin bad++; $display("FAIL bp_vs_fullrate: %0d diffs, got %0d beats want %0d", rd, got_q.size(), ref_q.size()); end
    d = stream_diffs();
    total++; if (d != 0) begin bad++; $display("FAIL bp_vs_model: %0d diffs", d); end
    total++; if (hb != 0) begin bad++; $display("FAIL bp_hold_stable: %0d unstable cycles want 0", hb); end
  endtask

  task automatic test_reset_mid_pay();
    int lows, hb, d;
    logic [31:0] w30;
    logic [32:0] b;
    reset_dut();
    in_q.delete();
    repeat (31) in_q.push_back($urandom);
    w30 = in_q[30];
    drive(31, 100, 100, 0, lows, hb);
    @(negedge clk);
    m_tready = 1'b0;
    s_tvalid = 1'b0;
    #1;
    total++; if (m_tvalid !== 1'b1 || m_tdata !== w30) begin bad++; $display("FAIL midpay_pending: got v=%b %h want v=1 %h", m_tvalid, m_tdata, w30); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (m_tvalid !== 1'b0 || m_tdata !== 32'd0) begin bad++; $display("FAIL midpay_async_clear: got v=%b %h want v=0 0", m_tvalid, m_tdata); end
    @(negedge clk);
    rst_n = 1'b1;
    m_cw = 0;
    m_blk = 0;
    in_q.delete();
    repeat (65) in_q.push_back($urandom);
    model_stream(65, 4);
    drive(67, 100, 100, 0, lows, hb);
    d = stream_diffs();
    total++; if (d != 0) begin bad++; $display("FAIL midpay_fresh_stream: %0d diffs", d); end
    b = (got_q.size() > 0) ? got_q[0] : '1;
    total++; if (b !== {1'b0, 32'hA5C3_0000}) begin bad++; $display("FAIL midpay_header: got %h want 0a5c30000", b); end
  endtask

  task automatic test_blk_wrap();
    int idx, cyc, ntr, d;
    logic [7:0] seq255, seq256;
    logic [31:0] h255, h256;
    reset_dut();
    in_q.delete();
    repeat (513) in_q.push_back($urandom);
    model_stream(2, 1);
    got_q.delete();
    idx = 0; cyc = 0; ntr = 0; seq255 = 'x; seq256 = 'x;
    while (got_q.size() < 1026 && cyc < BUDGET) begin
      @(negedge clk);
      sm_m_tready = 1'b1;
      sm_s_tvalid = (idx < in_q.size());
      if (idx < in_q.size()) sm_s_tdata = in_q[idx];
      #1;
      if (sm_s_tvalid && sm_s_tready === 1'b1) idx++;
      if (sm_m_tvalid === 1'b1) begin
        got_q.push_back({sm_m_tlast, sm_m_tdata});
        if (sm_m_tlast === 1'b1) begin
          ntr++;
          if (ntr == 255) seq255 = sm_blk_seq;
          if (ntr == 256) seq256 = sm_blk_seq;
        end
      end
      cyc++;
    end
    @(negedge clk);
    sm_s_tvalid = 1'b0;
    d = stream_diffs();
    total++; if (d != 0) begin bad++; $display("FAIL wrap_stream: %0d diffs, got %0d beats want 1026", d, got_q.size()); end
    total++; if (seq255 !== 8'hFF) begin bad++; $display("FAIL wrap_seq255: got %h want ff", seq255); end
    total++; if (seq256 !== 8'h00) begin bad++; $display("FAIL wrap_seq256: got %h want 00", seq256); end
    h255 = (got_q.size() > 1020) ? got_q[1020][31:0] : '0;
    h256 = (got_q.size() > 1024) ? got_q[1024][31:0] : '1;
    total++; if (h255 !== 32'hA5C3_00FF || h256 !== 32'hA5C3_0000) begin bad++; $display("FAIL wrap_header_bytes: got %h,%h want a5c300ff,a5c30000", h255, h256); end
  endtask

  initial begin
    build_table();
    test_reset();
    test_single_codeword();
    test_full_block();
    test_backpressure();
    test_reset_mid_pay();
    test_blk_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/codeword_crc_framer.md
Name: codeword_crc_framer

Overview:
- Downstream stage of the pre-interleaver. Consumes its serial 32-bit codeword stream, which has no tlast; codeword boundaries are implied by counting CODEWORD_SIZE_IN_32 words.
- Wraps each codeword as: one header word, the payload passed through unchanged, one CRC-32 trailer word. tlast is asserted on the trailer.
- Output feeds the FEC encoder / link transmitter, which needs explicit codeword framing and integrity check.

Parameters:
- CODEWORD_SIZE_IN_32, 65: payload words per codeword; legal range 2..255.
- NUM_CODEWORDS, 4: codewords per interleaver block; legal range 1..256. Sets header index wrap.
- SYNC_WORD, 16'hA5C3: header bits [31:16].

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  32  payload word from pre-interleaver.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  32  framed output word (registered).
- m_axis_tvalid  out  1  output valid (registered).
- m_axis_tlast  out  1  high on the CRC trailer word only (registered).
- m_axis_tready  in  1  downstream ready.
- blk_seq  out  8  count of completed interleaver blocks, mod 256.

Behaviour:
- Reset (async assert, sync-free release):
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, blk_seq=0.
  - FSM=HDR, word_cnt=0, cw_idx=0, crc=32'hFFFFFFFF.
  - Reset mid-codeword discards the partial codeword; no trailer is emitted.
- Output register slot:
  - slot_free = !m_axis_tvalid || m_axis_tready.
  - The register loads only when slot_free.
  - When an output is not loaded in a cycle where m_axis_tready=1, m_axis_tvalid clears.
  - Once asserted, m_axis_tvalid/tdata/tlast stay stable until m_axis_tready.
- s_axis_tready = (FSM==PAY) && slot_free. It is combinational from m_axis_tready and FSM state. It is 0 in HDR and CRC.
- FSM HDR:
  - Condition: s_axis_tvalid=1 && slot_free.
  - Action: load header {SYNC_WORD, cw_idx[7:0], blk_seq}, tlast=0, then go to PAY.
  - The header is never emitted without a pending input word, so there are no dangling headers.
  - The payload word is not consumed in this cycle.
- FSM PAY:
  - On s_axis_tvalid && s_axis_tready: load the payload word to the output (tlast=0), crc <= crc_next(crc, word), word_cnt++.
  - On accepting word index CODEWORD_SIZE_IN_32-1: word_cnt <= 0, go to CRC.
  - Latency: an accepted word appears on m_axis_tdata the next cycle.
- FSM CRC:
  - Condition: slot_free.
  - Action: load the final crc value, tlast=1, crc <= 32'hFFFFFFFF, go to HDR.
  - Index update: if cw_idx==NUM_CODEWORDS-1, then cw_idx <= 0 and blk_seq <= blk_seq+1 (wraps 255->0); else cw_idx++.
- CRC definition (CRC-32/MPEG-2):
  - Polynomial 0x04C11DB7, init 0xFFFFFFFF, no input/output reflection, no final XOR.
  - Each word is processed MSB first, bit 31 down to bit 0. This is equivalent to a big-endian byte stream.
  - Computed over payload words only; the header is excluded.
  - One word per cycle, as a combinational 32-bit-step function.
- Throughput: CODEWORD_SIZE_IN_32+2 output cycles per codeword at full rate. The input stalls exactly 2 cycles per codeword.
- Backpressure: with m_axis_tready=0 and valid held, no state advances and no input is accepted.
- Input bubbles: a tvalid low in PAY only pauses; the CRC is unaffected by gaps.
- Simultaneous events: in the same cycle the slot can unload (tready) and reload with the next word, giving full rate with no bubble.

Test Plan:
- Reset then idle: with s_axis_tvalid=0 held for 20 cycles -> m_axis_tvalid stays 0, s_axis_tready=0 (HDR), blk_seq=0.
- Single codeword, full rate, CODEWORD_SIZE_IN_32=65, words 0..64, m_axis_tready=1:
  - Outputs 67 beats: A5C3_0000, then 0x0..0x40, then a CRC equal to the reference model.
  - tlast only on beat 67.
  - s_axis_tready low exactly 2 cycles.
- Full block (4 codewords, 260 words of 0xFFFFFFFF):
  - Header indices are 0,1,2,3 with blk_seq byte 00.
  - blk_seq reads 1 after the 4th trailer.
  - The next header is A5C3_0001.
  - All 4 CRCs are identical and match the model.
- Random backpressure (m_axis_tready 50%) and input gaps (tvalid 70%) over 8 blocks:
  - The output stream is identical to the full-rate run.
  - No dropped or duplicated words.
  - tdata stable while valid && !ready.
- Reset asserted mid-PAY at word 30:
  - m_axis_tvalid drops immediately (async).
  - After release, the next input produces header A5C3_0000 and a fresh CRC over the new 65 words only.
- blk_seq wrap: 256 blocks fed -> blk_seq returns to 0; the header byte[7:0] sequence goes 0xFF then 0x00.
